// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the F/D pipeline register: owns the PC, flags
// AdEL on illegal fetch addresses and handles stall, branch, eret and exception entry.
module fetch_stage #(
   parameter logic [31:0] PC_RESET  = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [31:0] IM_BASE   = 32'h0000_3000,
   parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        d_is_branch,
   output logic [31:0] i_inst_addr,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] D_pc,
   output logic [31:0] D_instr,
   output logic [4:0]  D_exccode,
   output logic        D_bd
);

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   logic [31:0] f_pc;
   logic        f_adel;
   logic [31:0] f_pc_next;
   logic [31:0] d_pc_next;
   logic [31:0] d_instr_next;
   logic [4:0]  d_exccode_next;
   logic        d_bd_next;

   assign i_inst_addr = f_pc;
   assign f_adel = (f_pc[1:0] != 2'b00) || (f_pc < IM_BASE) || (f_pc > IM_LIMIT);

   // F and D share one priority chain so the two stages never drift apart.
   always_comb begin
      f_pc_next      = f_pc + 32'd4;
      d_pc_next      = f_pc;
      d_instr_next   = f_adel ? 32'd0 : i_inst_rdata;
      d_exccode_next = f_adel ? EXC_ADEL : EXC_NONE;
      d_bd_next      = d_is_branch;
      if (req) begin
         f_pc_next      = EXC_ENTRY;
         d_pc_next      = EXC_ENTRY;
         d_instr_next   = 32'd0;
         d_exccode_next = EXC_NONE;
         d_bd_next      = 1'b0;
      end else if (stall) begin
         f_pc_next      = f_pc;
         d_pc_next      = D_pc;
         d_instr_next   = D_instr;
         d_exccode_next = D_exccode;
         d_bd_next      = D_bd;
      end else if (eret) begin
         // The word fetched alongside eret is dropped: eret has no delay slot.
         f_pc_next      = epc;
         d_pc_next      = epc;
         d_instr_next   = 32'd0;
         d_exccode_next = EXC_NONE;
         d_bd_next      = 1'b0;
      end else if (br_taken) begin
         f_pc_next = br_target;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_pc      <= PC_RESET;
         D_pc      <= 32'd0;
         D_instr   <= 32'd0;
         D_exccode <= EXC_NONE;
         D_bd      <= 1'b0;
      end else begin
         f_pc      <= f_pc_next;
         D_pc      <= d_pc_next;
         D_instr   <= d_instr_next;
         D_exccode <= d_exccode_next;
         D_bd      <= d_bd_next;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected post-edge state,
// a negedge monitor pops and compares.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        req = 1'b0;
   logic        eret = 1'b0;
   logic [31:0] epc = 32'd0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = 32'd0;
   logic        d_is_branch = 1'b0;
   logic [31:0] i_inst_addr;
   logic [31:0] i_inst_rdata;
   logic [31:0] D_pc;
   logic [31:0] D_instr;
   logic [4:0]  D_exccode;
   logic        D_bd;

   fetch_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .req(req), .eret(eret), .epc(epc),
      .br_taken(br_taken), .br_target(br_target), .d_is_branch(d_is_branch),
      .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
      .D_pc(D_pc), .D_instr(D_instr), .D_exccode(D_exccode), .D_bd(D_bd)
   );

   // Instruction memory: each word is tagged with its own address.
   assign i_inst_rdata = {16'hC0DE, i_inst_addr[15:0]};

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          tag;
      logic [31:0] addr;
      logic [31:0] dpc;
      logic [31:0] dinstr;
      logic [4:0]  exc;
      logic        bd;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endfunction

   exp_t m;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].tag == cyc) begin
         m = q.pop_front();
         check({m.name, ".addr"},  i_inst_addr, m.addr);
         check({m.name, ".dpc"},   D_pc, m.dpc);
         check({m.name, ".instr"}, D_instr, m.dinstr);
         check({m.name, ".exc"},   {27'd0, D_exccode}, {27'd0, m.exc});
         check({m.name, ".bd"},    {31'd0, D_bd}, {31'd0, m.bd});
         $display("[TB] cyc %0d %s addr=%08h dpc=%08h instr=%08h exc=%0d bd=%0b",
                  cyc, m.name, i_inst_addr, D_pc, D_instr, D_exccode, D_bd);
      end
   end

   task automatic push(input string nm, input logic [31:0] ea, input logic [31:0] edp,
                       input logic [31:0] ein, input logic [4:0] eex, input logic ebd);
      exp_t e;
      e.name = nm; e.tag = cyc + 1; e.addr = ea; e.dpc = edp;
      e.dinstr = ein; e.exc = eex; e.bd = ebd;
      q.push_back(e);
   endtask

   // Drive one cycle of inputs at the negedge and queue the state expected after the next posedge.
   task automatic step(input string nm, input logic rs, input logic st, input logic rq,
                       input logic er, input logic [31:0] ep, input logic bt,
                       input logic [31:0] bta, input logic dbr,
                       input logic [31:0] ea, input logic [31:0] edp,
                       input logic [31:0] ein, input logic [4:0] eex, input logic ebd);
      @(negedge clk);
      reset = rs; stall = st; req = rq; eret = er; epc = ep;
      br_taken = bt; br_target = bta; d_is_branch = dbr;
      push(nm, ea, edp, ein, eex, ebd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //    name        rst st rq er epc          bt bta          dbr  addr          dpc           instr         exc bd
      step("reset",     1, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3000, 32'h0,        32'h0,        0, 0);
      step("run0",      0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3004, 32'h0000_3000, 32'hC0DE_3000, 0, 0);
      step("run1",      0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3008, 32'h0000_3004, 32'hC0DE_3004, 0, 0);
      step("stall0",    0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3008, 32'h0000_3004, 32'hC0DE_3004, 0, 0);
      step("stall1",    0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3008, 32'h0000_3004, 32'hC0DE_3004, 0, 0);
      step("stall2",    0, 1, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3008, 32'h0000_3004, 32'hC0DE_3004, 0, 0);
      step("resume",    0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_300C, 32'h0000_3008, 32'hC0DE_3008, 0, 0);
      step("br_slot",   0, 0, 0, 0, 32'h0,       1, 32'h3100,    1, 32'h0000_3100, 32'h0000_300C, 32'hC0DE_300C, 0, 1);
      step("br_tgt",    0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3104, 32'h0000_3100, 32'hC0DE_3100, 0, 0);
      step("eret",      0, 0, 0, 1, 32'h3200,    0, 32'h0,       0, 32'h0000_3200, 32'h0000_3200, 32'h0,        0, 0);
      step("eret_tgt",  0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3204, 32'h0000_3200, 32'hC0DE_3200, 0, 0);
      step("eret_stl",  0, 1, 0, 1, 32'h3300,    0, 32'h0,       0, 32'h0000_3204, 32'h0000_3200, 32'hC0DE_3200, 0, 0);
      step("br_mis",    0, 0, 0, 0, 32'h0,       1, 32'h3002,    0, 32'h0000_3002, 32'h0000_3204, 32'hC0DE_3204, 0, 0);
      step("adel_mis",  0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3006, 32'h0000_3002, 32'h0,        4, 0);
      step("br_high",   0, 0, 0, 0, 32'h0,       1, 32'h7000,    0, 32'h0000_7000, 32'h0000_3006, 32'h0,        4, 0);
      step("adel_hi",   0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_7004, 32'h0000_7000, 32'h0,        4, 0);
      step("br_lim",    0, 0, 0, 0, 32'h0,       1, 32'h6FFC,    0, 32'h0000_6FFC, 32'h0000_7004, 32'h0,        4, 0);
      step("lim_ok",    0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_7000, 32'h0000_6FFC, 32'hC0DE_6FFC, 0, 0);
      step("br_low",    0, 0, 0, 0, 32'h0,       1, 32'h2FFC,    0, 32'h0000_2FFC, 32'h0000_7000, 32'h0,        4, 0);
      step("adel_lo",   0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3000, 32'h0000_2FFC, 32'h0,        4, 0);
      step("req_all",   0, 1, 1, 0, 32'h0,       1, 32'h3100,    1, 32'h0000_4180, 32'h0000_4180, 32'h0,        0, 0);
      step("handler",   0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_4184, 32'h0000_4180, 32'hC0DE_4180, 0, 0);
      step("req_eret",  0, 0, 1, 1, 32'h3300,    0, 32'h0,       0, 32'h0000_4180, 32'h0000_4180, 32'h0,        0, 0);
      step("br_wrap",   0, 0, 0, 0, 32'h0,       1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0000_4180, 32'hC0DE_4180, 0, 0);
      step("wrap",      0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0,        4, 0);
      step("after_wrp", 0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_0004, 32'h0000_0000, 32'h0,        4, 0);
      step("nt_slot",   0, 0, 0, 0, 32'h0,       0, 32'h0,       1, 32'h0000_0008, 32'h0000_0004, 32'h0,        4, 1);
      step("pre_rst",   0, 1, 0, 0, 32'h0,       1, 32'h5000,    0, 32'h0000_0008, 32'h0000_0004, 32'h0,        4, 1);

      // Asynchronous reset mid-stall with a pending branch: must clear before any edge.
      @(negedge clk);
      #2;
      reset = 1'b1; stall = 1'b1; br_taken = 1'b1; br_target = 32'h5000;
      #1;
      check("async_rst.addr", i_inst_addr, 32'h0000_3000);
      check("async_rst.dpc",  D_pc, 32'h0);
      check("async_rst.exc",  {27'd0, D_exccode}, 32'h0);
      check("async_rst.bd",   {31'd0, D_bd}, 32'h0);
      $display("[TB] async reset addr=%08h dpc=%08h exc=%0d bd=%0b", i_inst_addr, D_pc, D_exccode, D_bd);
      push("rst_hold", 32'h0000_3000, 32'h0, 32'h0, 0, 0);
      step("rst_rel",   0, 0, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0000_3004, 32'h0000_3000, 32'hC0DE_3000, 0, 0);

      repeat (3) @(negedge clk);
      #1;
      check("queue_drained", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
